// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: traces every change of the CPU a0 result into a show-ahead
// FIFO drained over a valid/ready stream. Drops changes (and counts them)
// only when the FIFO is full and the consumer is not popping.
// Optional build macro A0_TRACE_TS_EN adds a free-running cycle stamp per
// entry, presented on out_time.
module a0_trace_fifo #(
  parameter int unsigned DEPTH = 16
`ifdef A0_TRACE_TS_EN
  , parameter int unsigned TS_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              a0,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
`ifdef A0_TRACE_TS_EN
  output logic [TS_W-1:0]          out_time,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [PW-1:0] level_n;
  logic [AW-1:0] wr_addr, rd_addr_n;
  logic [31:0]   last_a0;
  logic          primed;
  logic          push_req, full, pop, wr_en, drop;
  logic          valid_n, overflow_n;
  logic [31:0]   data_n;
  logic [15:0]   drop_cnt_n;

`ifdef A0_TRACE_TS_EN
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] time_n;
`endif

  // Change detect, push/pop arbitration and next-state of every output register
  always_comb begin
    push_req   = !primed || (a0 != last_a0);
    full       = (wr_ptr ^ rd_ptr) == PW'(DEPTH);
    pop        = out_valid && out_ready;
    wr_en      = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    wr_addr    = wr_ptr[AW-1:0];
    wr_ptr_n   = wr_en ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_n   = pop ? rd_ptr + PW'(1) : rd_ptr;
    rd_addr_n  = rd_ptr_n[AW-1:0];
    valid_n    = wr_ptr_n != rd_ptr_n;
    level_n    = level;
    overflow_n = overflow;
    drop_cnt_n = drop_cnt;

    if (wr_en && !pop)      level_n = level + PW'(1);
    else if (!wr_en && pop) level_n = level - PW'(1);

    // The new head is the entry being written this edge when the slot matches
    data_n = (wr_en && (wr_addr == rd_addr_n)) ? a0 : mem[rd_addr_n];

    if (clr_ovf) begin
      overflow_n = 1'b0;
      drop_cnt_n = 16'd0;
    end
    if (drop) begin
      overflow_n = 1'b1;
      if (clr_ovf)                  drop_cnt_n = 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt_n = drop_cnt + 16'd1;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      last_a0   <= '0;
      primed    <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      level     <= level_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      overflow  <= overflow_n;
      drop_cnt  <= drop_cnt_n;
      last_a0   <= a0;
      primed    <= 1'b1;
    end
  end

  // Data storage; flushing is done through the pointers, so no reset here
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_addr] <= a0;
  end

`ifdef A0_TRACE_TS_EN
  // Head stamp follows the same bypass rule as the head data
  always_comb begin
    time_n = (wr_en && (wr_addr == rd_addr_n)) ? ts_cnt : ts_mem[rd_addr_n];
  end

  // Free-running cycle counter and head stamp register
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt   <= '0;
      out_time <= '0;
    end else begin
      ts_cnt   <= ts_cnt + TS_W'(1);
      out_time <= time_n;
    end
  end

  // Stamp storage alongside the data
  always_ff @(posedge clk) begin
    if (!rst && wr_en) ts_mem[wr_addr] <= ts_cnt;
  end
`endif

endmodule
